// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Sequencing controller for the 3-stage IF/ID -> ID/EX -> EX/WB
//             pipeline. Mealy FSM: write-enables and synchronous clears are
//             combinational from state and inputs; state is registered.
//             Handles memory wait, two-cycle long write-back, taken-branch
//             squash and load-use stall.
//  Options  : PIPE_CTRL_PERF_EN - builds the stall/flush performance counters;
//             when undefined both counter ports read as zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_reg_write,
    input  logic        ex_branch_taken,
    input  logic        wb_mem_access,
    input  logic        wb_long_write,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_wb_we,
    output logic        if_id_reset,
    output logic        id_ex_reset,
    output logic        ex_wb_reset,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [1:0]  c_ST_RUN      = 2'd0;
    localparam logic [1:0]  c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0]  c_ST_LONG     = 2'd2;
    localparam logic [15:0] c_TIMEOUT     = 16'(MEM_TIMEOUT);

    logic [1:0]  r_state;
    logic [15:0] r_wait_cnt;
    logic        r_mem_timeout;

    logic [1:0]  w_next_state;
    logic        w_pc_we;
    logic        w_if_id_we;
    logic        w_id_ex_we;
    logic        w_ex_wb_we;
    logic        w_if_id_reset;
    logic        w_id_ex_reset;
    logic        w_ex_wb_reset;
    logic        w_flush;
    logic        w_load_use;

    // A load in EX whose destination is read by the instruction in ID; r0 never stalls
    assign w_load_use = ex_mem_reg_write && (ex_rd != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rd)) ||
                         (id_uses_rt && (id_rt == ex_rd)));

    // Priority-ordered output and next-state decode; the mem condition is only
    // live in RUN, the long condition in RUN and on the MEM_WAIT release cycle
    always_comb begin
        w_pc_we       = 1'b1;
        w_if_id_we    = 1'b1;
        w_id_ex_we    = 1'b1;
        w_ex_wb_we    = 1'b1;
        w_if_id_reset = 1'b0;
        w_id_ex_reset = 1'b0;
        w_ex_wb_reset = 1'b0;
        w_flush       = 1'b0;
        w_next_state  = c_ST_RUN;

        if (reset) begin
            w_pc_we       = 1'b0;
            w_if_id_we    = 1'b0;
            w_id_ex_we    = 1'b0;
            w_ex_wb_we    = 1'b0;
            w_if_id_reset = 1'b1;
            w_id_ex_reset = 1'b1;
            w_ex_wb_reset = 1'b1;
        end else if ((r_state == c_ST_MEM_WAIT) && !mem_ready) begin
            w_pc_we      = 1'b0;
            w_if_id_we   = 1'b0;
            w_id_ex_we   = 1'b0;
            w_ex_wb_we   = 1'b0;
            w_next_state = c_ST_MEM_WAIT;
        end else if ((r_state == c_ST_RUN) && wb_mem_access && !mem_ready) begin
            w_pc_we      = 1'b0;
            w_if_id_we   = 1'b0;
            w_id_ex_we   = 1'b0;
            w_ex_wb_we   = 1'b0;
            w_next_state = c_ST_MEM_WAIT;
        end else if ((r_state != c_ST_LONG) && wb_long_write) begin
            w_pc_we      = 1'b0;
            w_if_id_we   = 1'b0;
            w_id_ex_we   = 1'b0;
            w_ex_wb_we   = 1'b0;
            w_next_state = c_ST_LONG;
        end else if (ex_branch_taken) begin
            // Squash the two younger instructions; the branch itself retires
            w_if_id_reset = 1'b1;
            w_id_ex_reset = 1'b1;
            w_flush       = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID, bubble into ID/EX, let the load advance
            w_pc_we       = 1'b0;
            w_if_id_we    = 1'b0;
            w_id_ex_reset = 1'b1;
        end
    end

    // State, memory-wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_RUN;
            r_wait_cnt    <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state != c_ST_MEM_WAIT) && (w_next_state == c_ST_MEM_WAIT)) begin
                r_wait_cnt <= 16'd0;
            end else if ((r_state == c_ST_MEM_WAIT) && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
                if ((r_wait_cnt + 16'd1) == c_TIMEOUT) begin
                    r_mem_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Wrap-around performance counters for PC-hold cycles and branch squashes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!w_pc_we) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

    assign pc_we       = w_pc_we;
    assign if_id_we    = w_if_id_we;
    assign id_ex_we    = w_id_ex_we;
    assign ex_wb_we    = w_ex_wb_we;
    assign if_id_reset = w_if_id_reset;
    assign id_ex_reset = w_id_ex_reset;
    assign ex_wb_reset = w_ex_wb_reset;
    assign state       = r_state;
    assign mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4). Expected
//             outputs are queued as each cycle's stimulus is applied and
//             popped for comparison once the outputs have settled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  ex_rd;
    logic        ex_mem_reg_write;
    logic        ex_branch_taken;
    logic        wb_mem_access;
    logic        wb_long_write;
    logic        mem_ready;
    logic        pc_we;
    logic        if_id_we;
    logic        id_ex_we;
    logic        ex_wb_we;
    logic        if_id_reset;
    logic        id_ex_reset;
    logic        ex_wb_reset;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string      tag;
        logic [3:0] we;     // {pc, if_id, id_ex, ex_wb}
        logic [3:0] we_msk; // bits of 'we' that are compared
        logic [2:0] rst;    // {if_id, id_ex, ex_wb}
        logic [1:0] st;
        logic       to;
    } exp_t;

    exp_t r_sb_q[$];

    pipe_ctrl #(.MEM_TIMEOUT(4)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .ex_rd            (ex_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_branch_taken  (ex_branch_taken),
        .wb_mem_access    (wb_mem_access),
        .wb_long_write    (wb_long_write),
        .mem_ready        (mem_ready),
        .pc_we            (pc_we),
        .if_id_we         (if_id_we),
        .id_ex_we         (id_ex_we),
        .ex_wb_we         (ex_wb_we),
        .if_id_reset      (if_id_reset),
        .id_ex_reset      (id_ex_reset),
        .ex_wb_reset      (ex_wb_reset),
        .state            (state),
        .mem_timeout      (mem_timeout),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge
    task automatic drive(input logic r, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                         input logic ld, input logic br, input logic mem,
                         input logic lng, input logic rdy);
        @(negedge clk);
        reset            = r;
        id_rs            = rs;
        id_uses_rs       = urs;
        id_rt            = rt;
        id_uses_rt       = urt;
        ex_rd            = rd;
        ex_mem_reg_write = ld;
        ex_branch_taken  = br;
        wb_mem_access    = mem;
        wb_long_write    = lng;
        mem_ready        = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Queue the expected outputs for the cycle just driven, then compare
    task automatic expect_out(input string tag, input logic [3:0] we, input logic [3:0] msk,
                              input logic [2:0] rst, input logic [1:0] st, input logic to);
        exp_t e;
        exp_t p;
        e.tag = tag; e.we = we; e.we_msk = msk; e.rst = rst; e.st = st; e.to = to;
        r_sb_q.push_back(e);
        #1;
        p = r_sb_q.pop_front();
        check_eq({p.tag, "_we"},
                 {28'd0, {pc_we, if_id_we, id_ex_we, ex_wb_we} & p.we_msk},
                 {28'd0, p.we & p.we_msk});
        check_eq({p.tag, "_rst"}, {29'd0, if_id_reset, id_ex_reset, ex_wb_reset}, {29'd0, p.rst});
        check_eq({p.tag, "_state"}, {30'd0, state}, {30'd0, p.st});
        check_eq({p.tag, "_timeout"}, {31'd0, mem_timeout}, {31'd0, p.to});
    endtask

    task automatic check_perf(input string tag, input int exp_stall, input int exp_flush);
`ifdef PIPE_CTRL_PERF_EN
        check_eq({tag, "_stall_cycles"}, stall_cycles, 32'(exp_stall));
        check_eq({tag, "_flush_count"}, flush_count, 32'(exp_flush));
`else
        check_eq({tag, "_stall_cycles"}, stall_cycles, 32'd0 & 32'(exp_stall));
        check_eq({tag, "_flush_count"}, flush_count, 32'd0 & 32'(exp_flush));
`endif
    endtask

    initial begin
        reset = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rd = 5'd0; ex_mem_reg_write = 1'b0; ex_branch_taken = 1'b0;
        wb_mem_access = 1'b0; wb_long_write = 1'b0; mem_ready = 1'b1;

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            expect_out("reset", 4'b0000, 4'b1111, 3'b111, 2'd0, 1'b0);
        end
        check_perf("reset", 0, 0);

        idle();                                                                   expect_out("run_default", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);

        // Load-use on rs, then normal flow
        drive(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("lu_rs", 4'b0011, 4'b1111, 3'b010, 2'd0, 1'b0);
        idle();                                                                   expect_out("lu_after", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);
        // ex_rd = 0 never stalls
        drive(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("lu_rd0", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);
        // rt matches but is not read
        drive(1'b0, 5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("lu_rt_unused", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);
        // rt matches and is read
        drive(1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("lu_rt", 4'b0011, 4'b1111, 3'b010, 2'd0, 1'b0);
        // Branch wins over load-use
        drive(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); expect_out("branch_lu", 4'b1001, 4'b1001, 3'b110, 2'd0, 1'b0);
        idle();                                                                   expect_out("branch_after", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);
        check_perf("after_branch", 2, 1);

        // Memory freeze: one RUN cycle then three MEM_WAIT cycles, then release
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("mem_freeze", 4'b0000, 4'b1111, 3'b000, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("mem_wait", 4'b0000, 4'b1111, 3'b000, 2'd1, 1'b0);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("mem_release", 4'b1111, 4'b1111, 3'b000, 2'd1, 1'b0);
        idle();                                                                   expect_out("mem_after", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);
        check_perf("after_mem", 6, 1);

        // Long write: one freeze, then LONG (branch honoured there), then RUN
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); expect_out("long_freeze", 4'b0000, 4'b1111, 3'b000, 2'd0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); expect_out("long_branch", 4'b1001, 4'b1001, 3'b110, 2'd2, 1'b0);
        idle();                                                                   expect_out("long_after", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);

        // Mem wait and long write together: RUN -> MEM_WAIT -> LONG -> RUN
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); expect_out("ml_freeze", 4'b0000, 4'b1111, 3'b000, 2'd0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); expect_out("ml_wait_ready", 4'b0000, 4'b1111, 3'b000, 2'd1, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); expect_out("ml_long", 4'b1111, 4'b1111, 3'b000, 2'd2, 1'b0);
        idle();                                                                   expect_out("ml_after", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);
        check_perf("after_long", 9, 2);

        // Timeout after the fourth wait cycle, sticky past mem_ready
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("to_freeze", 4'b0000, 4'b1111, 3'b000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("to_wait", 4'b0000, 4'b1111, 3'b000, 2'd1, 1'b0);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("to_set", 4'b0000, 4'b1111, 3'b000, 2'd1, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); expect_out("to_release", 4'b1111, 4'b1111, 3'b000, 2'd1, 1'b1);
        idle();                                                                   expect_out("to_sticky", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b1);

        // Reset in the middle of MEM_WAIT clears state and timeout
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("rmw_freeze", 4'b0000, 4'b1111, 3'b000, 2'd0, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("rmw_wait", 4'b0000, 4'b1111, 3'b000, 2'd1, 1'b1);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("rmw_reset", 4'b0000, 4'b1111, 3'b111, 2'd1, 1'b1);
        idle();                                                                   expect_out("rmw_after", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);
        check_perf("after_reset", 0, 0);

        // Reset in the middle of LONG returns to RUN
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); expect_out("rl_freeze", 4'b0000, 4'b1111, 3'b000, 2'd0, 1'b0);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); expect_out("rl_reset", 4'b0000, 4'b1111, 3'b111, 2'd2, 1'b0);
        idle();                                                                   expect_out("rl_after", 4'b1111, 4'b1111, 3'b000, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 3-stage IF/ID → ID/EX → EX/WB core. It drives the write-enable and synchronous-clear inputs of the three pipeline registers and the PC write-enable. It resolves memory wait, two-cycle long write-back, taken-branch squash and load-use stall. It is a Mealy FSM: outputs are combinational from state and inputs, and state is registered.

## Interface
- MEM_TIMEOUT, default 255: MEM_WAIT cycles before `mem_timeout` sets; range 1..65535.
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in IF/ID.
- id_uses_rs, id_uses_rt  in  1 each  the instruction actually reads that source.
- ex_rd  in  5  destination register in ID/EX.
- ex_mem_reg_write  in  1  ID/EX holds a load.
- ex_branch_taken  in  1  branch in EX resolved taken.
- wb_mem_access  in  1  EX/WB holds a load or store (`mem_write | mem_reg_write`).
- wb_long_write  in  1  EX/WB holds a two-register write-back.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we, if_id_we, id_ex_we, ex_wb_we  out  1 each  register write-enables.
- if_id_reset, id_ex_reset, ex_wb_reset  out  1 each  register clears (bubble insert).
- state  out  2  RUN=0, MEM_WAIT=1, LONG=2.
- mem_timeout  out  1  sticky; set when the MEM_TIMEOUT limit is reached.
- stall_cycles, flush_count  out  32 each  perf counters (see Configuration).

## Operation
- Default in RUN with no condition active: all four `we` = 1, all three `*_reset` = 0.
- Conditions are evaluated in priority order:
  - Mem freeze: `wb_mem_access & !mem_ready` → all `we` = 0 and no resets; next state MEM_WAIT.
  - Long write: `wb_long_write` in RUN → all `we` = 0; next state LONG. The write-back unit performs its second write during LONG.
  - Branch: `ex_branch_taken` → `pc_we` = 1 (target), `ex_wb_we` = 1, `if_id_reset` = 1, `id_ex_reset` = 1. Two younger instructions are squashed.
  - Load-use: `ex_mem_reg_write`, `ex_rd` ≠ 0, and (`id_uses_rs & id_rs == ex_rd` or `id_uses_rt & id_rt == ex_rd`) → `pc_we` = 0, `if_id_we` = 0, `id_ex_reset` = 1, `ex_wb_we` = 1. One bubble is inserted.
- MEM_WAIT:
  - While `!mem_ready`: all `we` = 0; the wait counter increments.
  - On the `mem_ready` cycle: outputs follow the RUN rules with the mem condition masked. Next state is LONG if `wb_long_write`, else RUN.
- LONG: the RUN rules apply with the mem and long conditions masked. Next state is always RUN, so the same EX/WB content cannot re-trigger LONG.
- Wait counter: 16-bit, cleared on any entry to MEM_WAIT. When it equals MEM_TIMEOUT, `mem_timeout` sets and stays set until `reset`. The freeze continues regardless.

## Timing
- During `reset` = 1, overriding all else:
  - all `we` = 0; all `*_reset` = 1
  - state → RUN; `mem_timeout` → 0; counters → 0
  - The cycle after reset deasserts shows RUN defaults.
- Latency: zero cycles from inputs to outputs (combinational); state changes on the next edge.
- Reset mid-MEM_WAIT or mid-LONG: RUN on the next edge; no pending freeze is carried over.
- Simultaneous branch and load-use: branch wins, since the load-use target is squashed anyway.
- `ex_rd` = 0 never stalls.
- Mem freeze and long write coexisting: mem is handled first, then LONG.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every non-reset cycle with `pc_we` = 0.
  - `flush_count` increments on every branch squash.
  - Both are 32-bit, wrap-around, and cleared by `reset`.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset held 2 cycles: all `*_reset` = 1, all `we` = 0, `state` = 0. After release, all `we` = 1.
- Load in EX with `ex_rd` = 5, ID reads `id_rs` = 5: one cycle of `pc_we` = 0, `if_id_we` = 0, `id_ex_reset` = 1, then normal flow. Repeat with `ex_rd` = 0: no stall.
- `ex_branch_taken` = 1 together with a load-use match: `if_id_reset` = `id_ex_reset` = 1, `pc_we` = 1; `flush_count` +1 when `PIPE_CTRL_PERF_EN`.
- `wb_mem_access` = 1 with `mem_ready` low for 3 cycles: `state` = 1 and all `we` = 0 through those cycles; release on `mem_ready`; `stall_cycles` = 4.
- `wb_long_write` = 1: exactly one freeze cycle, `state` = 2, then RUN. Combined with a 1-cycle mem wait: RUN → MEM_WAIT → LONG → RUN.
- MEM_TIMEOUT = 4, `mem_ready` held low: `mem_timeout` rises after the 4th wait cycle and stays high after `mem_ready` returns; `reset` clears it.
